// File: rtl/load_store_unit_pkg.sv
// Shared CPU constants for the load/store path: bus widths, LSU command
// encodings and the alignment rule used by both the FSM and lane steering.
package load_store_unit_pkg;

    localparam int CPU_ADDR_WIDTH = 32;
    localparam int CPU_DATA_WIDTH = 32;

    localparam logic [1:0] CPU_LSU_IDLE  = 2'd0;
    localparam logic [1:0] CPU_LSU_BYTE  = 2'd1;
    localparam logic [1:0] CPU_LSU_HWORD = 2'd2;
    localparam logic [1:0] CPU_LSU_WORD  = 2'd3;

    // Bytes are never misaligned; halfwords need addr[0]=0, words addr[1:0]=0.
    function automatic logic lsu_misaligned(input logic [1:0] cmd, input logic [1:0] addr_lo);
        case (cmd)
            CPU_LSU_HWORD: return addr_lo[0];
            CPU_LSU_WORD:  return addr_lo != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_lane_steer.sv
// Big-endian lane steering: byte enables and replicated store data for a new
// command, and right-aligned zero-filled extraction of returned load data.
module lsu_lane_steer
    import load_store_unit_pkg::*;
(
    input  logic [1:0]                st_size,
    input  logic [1:0]                st_addr_lo,
    input  logic [CPU_DATA_WIDTH-1:0] st_data,
    output logic [3:0]                ben,
    output logic [CPU_DATA_WIDTH-1:0] lane_wdata,
    input  logic [1:0]                ld_size,
    input  logic [1:0]                ld_addr_lo,
    input  logic [CPU_DATA_WIDTH-1:0] ld_bus_data,
    output logic [CPU_DATA_WIDTH-1:0] ld_data
);

    logic [CPU_DATA_WIDTH-1:0] ld_shift;

    // Byte offset 0 is the most significant lane, so shift by (3 - offset) bytes.
    assign ld_shift = ld_bus_data >> {~ld_addr_lo, 3'b000};

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        ben        = 4'b0000;
        lane_wdata = '0;
        ld_data    = '0;

        case (st_size)
            CPU_LSU_BYTE: begin
                ben        = 4'b1000 >> st_addr_lo;
                lane_wdata = {4{st_data[7:0]}};
            end
            CPU_LSU_HWORD: begin
                ben        = st_addr_lo[1] ? 4'b0011 : 4'b1100;
                lane_wdata = {2{st_data[15:0]}};
            end
            CPU_LSU_WORD: begin
                ben        = 4'b1111;
                lane_wdata = st_data;
            end
            default: ;
        endcase

        case (ld_size)
            CPU_LSU_BYTE:  ld_data = {24'd0, ld_shift[7:0]};
            CPU_LSU_HWORD: ld_data = {16'd0, ld_addr_lo[1] ? ld_bus_data[15:0] : ld_bus_data[31:16]};
            CPU_LSU_WORD:  ld_data = ld_bus_data;
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging the memory stage to a
// request/ack/ready bus with big-endian byte lanes and error reporting.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CPU_ADDR_WIDTH-1:0] lsu_addr,
    input  logic [CPU_DATA_WIDTH-1:0] lsu_wdata,
    input  logic [1:0]                lsu_cmd,
    input  logic                      lsu_rnw,
    output logic [CPU_DATA_WIDTH-1:0] lsu_rdata,
    output logic                      lsu_busy,
    output logic                      lsu_err_align,
    output logic                      lsu_err_bus,
    output logic                      bus_req,
    output logic                      bus_rnw,
    output logic [CPU_ADDR_WIDTH-1:0] bus_addr,
    output logic [3:0]                bus_ben,
    output logic [CPU_DATA_WIDTH-1:0] bus_wdata,
    input  logic                      bus_ack,
    input  logic                      bus_rdy,
    input  logic                      bus_err,
    input  logic [CPU_DATA_WIDTH-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                    state;
    logic [1:0]                size_q;
    logic [1:0]                addr_lo_q;
    logic                      cmd_valid;
    logic                      cmd_misaligned;
    logic                      complete;
    logic [3:0]                steer_ben;
    logic [CPU_DATA_WIDTH-1:0] steer_wdata;
    logic [CPU_DATA_WIDTH-1:0] steer_rdata;

    assign cmd_misaligned = lsu_misaligned(lsu_cmd, lsu_addr[1:0]);
    assign cmd_valid      = (lsu_cmd != CPU_LSU_IDLE) && !cmd_misaligned;

    // Busy rises in the command cycle itself so the pipeline stalls immediately.
    assign lsu_busy = (state != S_IDLE) || cmd_valid;

    // A response may arrive together with the ack, skipping WAIT entirely.
    assign complete = bus_rdy && ((state == S_REQ && bus_ack) || state == S_WAIT);

    lsu_lane_steer u_lane_steer (
        .st_size     (lsu_cmd),
        .st_addr_lo  (lsu_addr[1:0]),
        .st_data     (lsu_wdata),
        .ben         (steer_ben),
        .lane_wdata  (steer_wdata),
        .ld_size     (size_q),
        .ld_addr_lo  (addr_lo_q),
        .ld_bus_data (bus_rdata),
        .ld_data     (steer_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            bus_req       <= 1'b0;
            bus_rnw       <= 1'b0;
            bus_addr      <= '0;
            bus_ben       <= 4'b0000;
            bus_wdata     <= '0;
            size_q        <= CPU_LSU_IDLE;
            addr_lo_q     <= 2'b00;
            lsu_rdata     <= '0;
            lsu_err_align <= 1'b0;
            lsu_err_bus   <= 1'b0;
        end else begin
            lsu_err_align <= 1'b0;
            lsu_err_bus   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state     <= S_REQ;
                        bus_req   <= 1'b1;
                        bus_rnw   <= lsu_rnw;
                        bus_addr  <= {lsu_addr[CPU_ADDR_WIDTH-1:2], 2'b00};
                        bus_ben   <= steer_ben;
                        bus_wdata <= steer_wdata;
                        size_q    <= lsu_cmd;
                        addr_lo_q <= lsu_addr[1:0];
                    end else if (lsu_cmd != CPU_LSU_IDLE) begin
                        lsu_err_align <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= bus_rdy ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus_rdy) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (complete) begin
                if (bus_err)      lsu_err_bus <= 1'b1;
                else if (bus_rnw) lsu_rdata   <= steer_rdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed vectors covering lane
// steering, misalignment, delayed ack, bus errors, ignored commands and reset.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [1:0]  lsu_cmd;
    logic        lsu_rnw;
    logic [31:0] lsu_rdata;
    logic        lsu_busy;
    logic        lsu_err_align;
    logic        lsu_err_bus;
    logic        bus_req;
    logic        bus_rnw;
    logic [31:0] bus_addr;
    logic [3:0]  bus_ben;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_rdy;
    logic        bus_err;
    logic [31:0] bus_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk           (clk),
        .rst           (rst),
        .lsu_addr      (lsu_addr),
        .lsu_wdata     (lsu_wdata),
        .lsu_cmd       (lsu_cmd),
        .lsu_rnw       (lsu_rnw),
        .lsu_rdata     (lsu_rdata),
        .lsu_busy      (lsu_busy),
        .lsu_err_align (lsu_err_align),
        .lsu_err_bus   (lsu_err_bus),
        .bus_req       (bus_req),
        .bus_rnw       (bus_rnw),
        .bus_addr      (bus_addr),
        .bus_ben       (bus_ben),
        .bus_wdata     (bus_wdata),
        .bus_ack       (bus_ack),
        .bus_rdy       (bus_rdy),
        .bus_err       (bus_err),
        .bus_rdata     (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive_cmd(input logic [1:0] cmd, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic rnw);
        lsu_cmd   = cmd;
        lsu_addr  = addr;
        lsu_wdata = wdata;
        lsu_rnw   = rnw;
    endtask

    task automatic drive_bus(input logic ack, input logic rdy, input logic err, input logic [31:0] rdata);
        bus_ack   = ack;
        bus_rdy   = rdy;
        bus_err   = err;
        bus_rdata = rdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive_cmd(CPU_LSU_IDLE, 32'h0, 32'h0, 1'b0);
        drive_bus(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        check_bit("rst_bus_req", bus_req, 1'b0);
        check_bit("rst_busy", lsu_busy, 1'b0);
        check_bit("rst_bus_rnw", bus_rnw, 1'b0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_ben", {28'd0, bus_ben}, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_rdata", lsu_rdata, 32'h0);
        check_bit("rst_err_align", lsu_err_align, 1'b0);
        check_bit("rst_err_bus", lsu_err_bus, 1'b0);
        @(negedge clk); rst = 1'b0;

        // Byte load at 0x103, ack+rdy together: busy exactly two cycles
        @(negedge clk); drive_cmd(CPU_LSU_BYTE, 32'h103, 32'h0, 1'b1); #1;
        check_bit("t1_busy_cmd", lsu_busy, 1'b1);
        check_bit("t1_req_cmd", bus_req, 1'b0);
        @(negedge clk); drive_cmd(CPU_LSU_IDLE, 32'h0, 32'h0, 1'b0);
        drive_bus(1'b1, 1'b1, 1'b0, 32'h11223344); #1;
        check_bit("t1_req", bus_req, 1'b1);
        check("t1_addr", bus_addr, 32'h100);
        check("t1_ben", {28'd0, bus_ben}, 32'h1);
        check_bit("t1_rnw", bus_rnw, 1'b1);
        check_bit("t1_busy_req", lsu_busy, 1'b1);
        @(negedge clk); drive_bus(1'b0, 1'b0, 1'b0, 32'h0); #1;
        check_bit("t1_busy_done", lsu_busy, 1'b0);
        check("t1_rdata", lsu_rdata, 32'h00000044);
        check_bit("t1_req_done", bus_req, 1'b0);

        // Halfword store at 0x202 with separate ack and rdy
        @(negedge clk); drive_cmd(CPU_LSU_HWORD, 32'h202, 32'h0000ABCD, 1'b0); #1;
        check_bit("t2_busy_cmd", lsu_busy, 1'b1);
        @(negedge clk); drive_cmd(CPU_LSU_IDLE, 32'h0, 32'h0, 1'b0); #1;
        check_bit("t2_req", bus_req, 1'b1);
        check("t2_addr", bus_addr, 32'h200);
        check("t2_ben", {28'd0, bus_ben}, 32'h3);
        check("t2_wdata", bus_wdata, 32'hABCDABCD);
        check_bit("t2_rnw", bus_rnw, 1'b0);
        @(negedge clk); drive_bus(1'b1, 1'b0, 1'b0, 32'h0); #1;
        check_bit("t2_req_ack", bus_req, 1'b1);
        @(negedge clk); drive_bus(1'b0, 1'b0, 1'b0, 32'h0); #1;
        check_bit("t2_req_wait", bus_req, 1'b0);
        check_bit("t2_busy_wait", lsu_busy, 1'b1);
        @(negedge clk); drive_bus(1'b0, 1'b1, 1'b0, 32'h99999999); #1;
        check_bit("t2_busy_rdy", lsu_busy, 1'b1);
        @(negedge clk); drive_bus(1'b0, 1'b0, 1'b0, 32'h0); #1;
        check_bit("t2_busy_done", lsu_busy, 1'b0);
        check("t2_rdata_kept", lsu_rdata, 32'h00000044);
        check_bit("t2_err_bus", lsu_err_bus, 1'b0);

        // Misaligned word load at 0x301
        @(negedge clk); drive_cmd(CPU_LSU_WORD, 32'h301, 32'h0, 1'b1); #1;
        check_bit("t3_busy_cmd", lsu_busy, 1'b0);
        check_bit("t3_align_early", lsu_err_align, 1'b0);
        @(negedge clk); drive_cmd(CPU_LSU_IDLE, 32'h0, 32'h0, 1'b0); #1;
        check_bit("t3_align", lsu_err_align, 1'b1);
        check_bit("t3_req", bus_req, 1'b0);
        check_bit("t3_busy", lsu_busy, 1'b0);
        @(negedge clk); #1;
        check_bit("t3_align_clr", lsu_err_align, 1'b0);
        check_bit("t3_req_after", bus_req, 1'b0);

        // Word load, ack after 3 idle REQ cycles, error response 2 cycles later
        @(negedge clk); drive_cmd(CPU_LSU_WORD, 32'h400, 32'h0, 1'b1); #1;
        check_bit("t4_busy_cmd", lsu_busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive_cmd(CPU_LSU_IDLE, 32'h0, 32'h0, 1'b0); #1;
            check_bit("t4_req_hold", bus_req, 1'b1);
            check("t4_addr_hold", bus_addr, 32'h400);
        end
        @(negedge clk); drive_bus(1'b1, 1'b0, 1'b0, 32'h0); #1;
        check_bit("t4_req_ack", bus_req, 1'b1);
        check("t4_ben", {28'd0, bus_ben}, 32'hF);
        @(negedge clk); drive_bus(1'b0, 1'b0, 1'b0, 32'h0); #1;
        check_bit("t4_req_wait", bus_req, 1'b0);
        check_bit("t4_busy_wait", lsu_busy, 1'b1);
        @(negedge clk); drive_bus(1'b0, 1'b1, 1'b1, 32'hDEADBEEF); #1;
        check_bit("t4_err_early", lsu_err_bus, 1'b0);
        @(negedge clk); drive_bus(1'b0, 1'b0, 1'b0, 32'h0); #1;
        check_bit("t4_err_bus", lsu_err_bus, 1'b1);
        check_bit("t4_busy_done", lsu_busy, 1'b0);
        check("t4_rdata_kept", lsu_rdata, 32'h00000044);
        @(negedge clk); #1;
        check_bit("t4_err_clr", lsu_err_bus, 1'b0);

        // Commands while busy are ignored
        @(negedge clk); drive_cmd(CPU_LSU_BYTE, 32'h101, 32'h0, 1'b1); #1;
        @(negedge clk); drive_cmd(CPU_LSU_WORD, 32'h500, 32'h12345678, 1'b0); #1;
        check("t5_addr", bus_addr, 32'h100);
        check("t5_ben", {28'd0, bus_ben}, 32'h4);
        check_bit("t5_rnw", bus_rnw, 1'b1);
        @(negedge clk); drive_cmd(CPU_LSU_IDLE, 32'h0, 32'h0, 1'b0);
        drive_bus(1'b1, 1'b0, 1'b0, 32'h0); #1;
        check("t5_addr_ack", bus_addr, 32'h100);
        @(negedge clk); drive_cmd(CPU_LSU_HWORD, 32'h600, 32'h0, 1'b1);
        drive_bus(1'b0, 1'b1, 1'b0, 32'hAABBCCDD); #1;
        check_bit("t5_busy_wait", lsu_busy, 1'b1);
        @(negedge clk); drive_cmd(CPU_LSU_IDLE, 32'h0, 32'h0, 1'b0);
        drive_bus(1'b0, 1'b0, 1'b0, 32'h0); #1;
        check_bit("t5_busy_done", lsu_busy, 1'b0);
        check("t5_rdata", lsu_rdata, 32'h000000BB);
        check_bit("t5_req_done", bus_req, 1'b0);
        @(negedge clk); #1;
        check_bit("t5_no_second", bus_req, 1'b0);
        check("t5_addr_final", bus_addr, 32'h100);

        // Upper halfword load and byte store replication
        @(negedge clk); drive_cmd(CPU_LSU_HWORD, 32'h010, 32'h0, 1'b1); #1;
        @(negedge clk); drive_cmd(CPU_LSU_IDLE, 32'h0, 32'h0, 1'b0);
        drive_bus(1'b1, 1'b1, 1'b0, 32'h12345678); #1;
        check("t6_hw_ben", {28'd0, bus_ben}, 32'hC);
        check("t6_hw_addr", bus_addr, 32'h010);
        @(negedge clk); drive_bus(1'b0, 1'b0, 1'b0, 32'h0); #1;
        check("t6_hw_rdata", lsu_rdata, 32'h00001234);
        @(negedge clk); drive_cmd(CPU_LSU_BYTE, 32'h002, 32'hFFFFFF5A, 1'b0); #1;
        @(negedge clk); drive_cmd(CPU_LSU_IDLE, 32'h0, 32'h0, 1'b0);
        drive_bus(1'b1, 1'b1, 1'b0, 32'h0); #1;
        check("t6_b_ben", {28'd0, bus_ben}, 32'h2);
        check("t6_b_wdata", bus_wdata, 32'h5A5A5A5A);
        check("t6_b_addr", bus_addr, 32'h000);
        @(negedge clk); drive_bus(1'b0, 1'b0, 1'b0, 32'h0); #1;
        check("t6_b_rdata_kept", lsu_rdata, 32'h00001234);
        check_bit("t6_b_busy", lsu_busy, 1'b0);

        // Stray bus handshakes in IDLE are ignored
        @(negedge clk); drive_bus(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF); #1;
        check_bit("t7_req", bus_req, 1'b0);
        check_bit("t7_busy", lsu_busy, 1'b0);
        @(negedge clk); drive_bus(1'b0, 1'b0, 1'b0, 32'h0); #1;
        check_bit("t7_err_bus", lsu_err_bus, 1'b0);
        check("t7_rdata", lsu_rdata, 32'h00001234);

        // Reset in WAIT abandons the transaction; next command completes
        @(negedge clk); drive_cmd(CPU_LSU_WORD, 32'h700, 32'h0, 1'b1); #1;
        @(negedge clk); drive_cmd(CPU_LSU_IDLE, 32'h0, 32'h0, 1'b0);
        drive_bus(1'b1, 1'b0, 1'b0, 32'h0); #1;
        @(negedge clk); drive_bus(1'b0, 1'b0, 1'b0, 32'h0); #1;
        check_bit("t8_busy_wait", lsu_busy, 1'b1);
        @(negedge clk); rst = 1'b1; #1;
        check_bit("t8_rst_req", bus_req, 1'b0);
        check_bit("t8_rst_busy", lsu_busy, 1'b0);
        check("t8_rst_addr", bus_addr, 32'h0);
        check("t8_rst_rdata", lsu_rdata, 32'h0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); drive_cmd(CPU_LSU_WORD, 32'h800, 32'h0, 1'b1); #1;
        check_bit("t8_busy_cmd", lsu_busy, 1'b1);
        @(negedge clk); drive_cmd(CPU_LSU_IDLE, 32'h0, 32'h0, 1'b0);
        drive_bus(1'b1, 1'b1, 1'b0, 32'hCAFEF00D); #1;
        check("t8_addr", bus_addr, 32'h800);
        check_bit("t8_req", bus_req, 1'b1);
        @(negedge clk); drive_bus(1'b0, 1'b0, 1'b0, 32'h0); #1;
        check("t8_rdata", lsu_rdata, 32'hCAFEF00D);
        check_bit("t8_busy_done", lsu_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
